// File: rtl/armstrong_pkg.sv
// rtl/armstrong_pkg.sv - shared types and constants for the Armstrong number checker
package armstrong_pkg;

  localparam int RADIX = 10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    COUNT = 3'd1,
    LOAD  = 3'd2,
    DIGIT = 3'd3,
    POW   = 3'd4,
    ACC   = 3'd5,
    DONE  = 3'd6
  } state_t;

  // Number of decimal digits needed for the largest w-bit value, 2^w-1.
  function automatic int dec_digits(input int w);
    longint unsigned v;
    int n;
    v = (64'd1 << w) - 64'd1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      if (v != 64'd0) begin
        n++;
        v = v / 64'(RADIX);
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/digit_pow.sv
// rtl/digit_pow.sv - sequential saturating d^k power unit, one multiply per cycle
module digit_pow #(
  parameter int W  = 9,
  parameter int KW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [3:0]    d,
  input  logic [KW-1:0] k,
  output logic [W:0]    pw,
  output logic          sat,
  output logic          done
);

  localparam logic [W:0] SAT_VAL = {1'b1, {W{1'b0}}};

  logic [3:0]    d_q;
  logic [KW-1:0] e;
  logic          busy;
  logic [W+4:0]  prod;
  logic          prod_over;

  assign prod      = {4'b0000, pw} * {{(W + 1){1'b0}}, d_q};
  assign prod_over = |prod[W+4:W];
  // done marks the last multiply cycle so the caller leaves on the same edge
  assign done      = busy && (e == k - KW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      d_q  <= '0;
      e    <= '0;
      pw   <= '0;
      sat  <= 1'b0;
      busy <= 1'b0;
    end else if (start) begin
      d_q  <= d;
      e    <= '0;
      pw   <= (W + 1)'(1);
      sat  <= 1'b0;
      busy <= 1'b1;
    end else if (busy) begin
      pw  <= prod_over ? SAT_VAL : prod[W:0];
      sat <= sat | prod_over;
      e   <= e + KW'(1);
      if (done) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/armstrong_seq.sv
// rtl/armstrong_seq.sv - streaming Armstrong number checker with one shared power datapath
module armstrong_seq
  import armstrong_pkg::*;
#(
  parameter  int W    = 9,
  localparam int MAXD = dec_digits(W),
  localparam int KW   = $clog2(MAXD + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_num,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_num,
  output logic [KW-1:0] out_digits,
  output logic          is_armstrong
);

  localparam logic [W:0] SAT_VAL = {1'b1, {W{1'b0}}};

  state_t        state, state_nxt;
  logic [W-1:0]  num;
  logic [W-1:0]  tmp;
  logic [W-1:0]  tmp_div;
  logic [3:0]    tmp_mod;
  logic [KW-1:0] k;
  logic [W:0]    sum;
  logic [W:0]    sum_nxt;
  logic [W+1:0]  sum_ext;
  logic          sum_over;
  logic          ovf;

  logic          pow_start;
  logic [W:0]    pow_pw;
  logic          pow_sat;
  logic          pow_done;

  // Division by the constant radix only; no general divider
  assign tmp_div  = tmp / W'(RADIX);
  assign tmp_mod  = 4'(tmp % W'(RADIX));

  assign sum_ext  = {1'b0, sum} + {1'b0, pow_pw};
  assign sum_over = sum_ext[W+1] | sum_ext[W];
  assign sum_nxt  = sum_over ? SAT_VAL : sum_ext[W:0];

  assign out_num    = num;
  assign out_digits = k;

  digit_pow #(
    .W  (W),
    .KW (KW)
  ) u_digit_pow (
    .clk   (clk),
    .rst   (rst),
    .start (pow_start),
    .d     (tmp_mod),
    .k     (k),
    .pw    (pow_pw),
    .sat   (pow_sat),
    .done  (pow_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = COUNT;
      COUNT:   if (tmp_div == '0) state_nxt = LOAD;
      LOAD:    state_nxt = DIGIT;
      DIGIT:   state_nxt = POW;
      POW:     if (pow_done) state_nxt = ACC;
      ACC:     state_nxt = (tmp == '0) ? DONE : DIGIT;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    pow_start    = 1'b0;
    is_armstrong = 1'b0;
    case (state)
      IDLE:  in_ready = 1'b1;
      DIGIT: pow_start = 1'b1;
      DONE: begin
        out_valid    = 1'b1;
        is_armstrong = !ovf && (sum == {1'b0, num});
      end
      default: ;
    endcase
  end

  // tmp is reused: digit counting first, then digit extraction after LOAD
  always_ff @(posedge clk) begin
    if (rst) begin
      num <= '0;
      tmp <= '0;
      k   <= '0;
      sum <= '0;
      ovf <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            num <= in_num;
            tmp <= in_num;
            k   <= '0;
            ovf <= 1'b0;
          end
        end
        COUNT: begin
          tmp <= tmp_div;
          k   <= k + KW'(1);
        end
        LOAD: begin
          tmp <= num;
          sum <= '0;
        end
        DIGIT: tmp <= tmp_div;
        ACC: begin
          sum <= sum_nxt;
          ovf <= ovf | pow_sat | sum_over;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_armstrong_seq.sv
// tb/tb_armstrong_seq.sv - self-checking bench for armstrong_seq at W=9 and W=16
module tb_armstrong_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic        sel;
  logic [15:0] in_num;
  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          last_acc;

  logic        in_ready9, out_valid9, arm9;
  logic [8:0]  out_num9;
  logic [1:0]  out_digits9;
  logic        in_ready16, out_valid16, arm16;
  logic [15:0] out_num16;
  logic [2:0]  out_digits16;

  logic        cur_in_ready, cur_out_valid, cur_arm;
  logic [15:0] cur_num;
  logic [2:0]  cur_digits;

  assign cur_in_ready  = sel ? in_ready16  : in_ready9;
  assign cur_out_valid = sel ? out_valid16 : out_valid9;
  assign cur_arm       = sel ? arm16       : arm9;
  assign cur_num       = sel ? out_num16   : {7'b0, out_num9};
  assign cur_digits    = sel ? out_digits16 : {1'b0, out_digits9};

  armstrong_seq #(.W(9)) u_dut9 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid & ~sel),
    .in_ready     (in_ready9),
    .in_num       (in_num[8:0]),
    .out_valid    (out_valid9),
    .out_ready    (out_ready & ~sel),
    .out_num      (out_num9),
    .out_digits   (out_digits9),
    .is_armstrong (arm9)
  );

  armstrong_seq #(.W(16)) u_dut16 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid & sel),
    .in_ready     (in_ready16),
    .in_num       (in_num),
    .out_valid    (out_valid16),
    .out_ready    (out_ready & sel),
    .out_num      (out_num16),
    .out_digits   (out_digits16),
    .is_armstrong (arm16)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: decimal digits, exact sum of digit^k, verdict by plain arithmetic
  task automatic model(input longint n, output int k, output bit arm);
    longint t, s, p;
    int dg[$];
    t = n;
    k = 0;
    do begin
      dg.push_back(int'(t % 10));
      t = t / 10;
      k++;
    end while (t != 0);
    s = 0;
    foreach (dg[i]) begin
      p = 1;
      repeat (k) p = p * dg[i];
      s = s + p;
    end
    arm = (s == n);
  endtask

  // Called and returns at a negedge. mode: 0 drop valid, 1 hold valid with next_n, 2 junk while busy
  task automatic send(input longint n, input int stall_max, input int mode, input longint next_n);
    int k_exp, lat, guard, exp_lat;
    bit arm_exp;
    logic [15:0] h_num;
    logic [2:0]  h_dig;
    logic        h_arm;
    model(n, k_exp, arm_exp);
    exp_lat = k_exp + 1 + k_exp * (k_exp + 2);
    in_valid = 1'b1;
    in_num   = 16'(n);
    guard = 0;
    while (!cur_in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("accept_wait", longint'(guard < 300), 1);
    @(posedge clk);
    #1;
    last_acc = cyc;
    if (mode == 1) in_num = 16'(next_n);
    else in_valid = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!cur_out_valid && lat < 300) begin
      chk("busy_in_ready", longint'(cur_in_ready), 0);
      if (mode == 2) begin
        in_valid = 1'($urandom_range(0, 1));
        in_num   = 16'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    if (mode == 2) in_valid = 1'b0;
    chk("latency", lat, exp_lat);
    chk("out_num", longint'(cur_num), n);
    chk("out_digits", longint'(cur_digits), k_exp);
    chk("is_armstrong", longint'(cur_arm), longint'(arm_exp));
    h_num = cur_num;
    h_dig = cur_digits;
    h_arm = cur_arm;
    repeat ($urandom_range(0, stall_max)) begin
      @(negedge clk);
      chk("stall_valid", longint'(cur_out_valid), 1);
      chk("stall_stable", longint'({cur_num, cur_digits, cur_arm}), longint'({h_num, h_dig, h_arm}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("after_take_valid", longint'(cur_out_valid), 0);
    chk("after_take_ready", longint'(cur_in_ready), 1);
  endtask

  initial begin
    int a1, gap;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel       = 1'b0;
    in_num    = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", longint'(in_ready9), 1);
    chk("rst_out_valid", longint'(out_valid9), 0);
    chk("rst_out_num", longint'(out_num9), 0);
    chk("rst_out_digits", longint'(out_digits9), 0);
    chk("rst_is_armstrong", longint'(arm9), 0);
    rst = 1'b0;
    @(negedge clk);

    send(153, 0, 0, 0);
    send(154, 0, 1, 0);
    a1 = last_acc;
    send(0, 0, 0, 0);
    gap = last_acc - a1;
    chk("b2b_gap", gap, 19 + 2);

    // Abort 370 with a reset sampled on the 8th edge after accept
    in_valid = 1'b1;
    in_num   = 16'd370;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_in_ready", longint'(in_ready9), 1);
    chk("abort_out_valid", longint'(out_valid9), 0);
    chk("abort_out_num", longint'(out_num9), 0);
    chk("abort_out_digits", longint'(out_digits9), 0);
    chk("abort_is_armstrong", longint'(arm9), 0);
    repeat (30) begin
      @(negedge clk);
      chk("abort_no_valid", longint'(out_valid9), 0);
    end
    send(371, 0, 0, 0);
    send(407, 2, 2, 0);

    for (int n = 0; n < 512; n++) send(n, 3, 0, 0);

    sel = 1'b1;
    @(negedge clk);
    send(9474, 0, 0, 0);
    send(59999, 0, 0, 0);
    repeat (20) send(longint'($urandom_range(0, 65535)), 2, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/armstrong_seq.md
# armstrong_seq

Parametrised, multi-cycle Armstrong (narcissistic) number checker. It accepts an unsigned W-bit number over a valid/ready handshake and counts its decimal digits k. It then sums each digit raised to the k-th power using one iterative multiplier and returns the verdict over a second valid/ready handshake. It replaces the fixed 9-bit, fixed-cube combinational checker wherever numbers arrive as a stream and a single shared datapath is preferred.

## Interface
- W, default 9: input number width in bits (4..32).
- MAXD, derived localparam: decimal digits of 2^W-1. W=9 gives 3; W=16 gives 5.
- KW, derived localparam: clog2(MAXD+1), the width of the digit count.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_num is valid.
- in_ready  output  1  block is idle and can accept a number.
- in_num  input  W  unsigned number to check.
- out_valid  output  1  result is valid and held until taken.
- out_ready  input  1  consumer takes the result.
- out_num  output  W  echo of the checked number.
- out_digits  output  KW  digit count k; 0 counts as 1 digit.
- is_armstrong  output  1  1 when the sum of digit^k equals the number.

## Operation
- States: IDLE, COUNT, LOAD, DIGIT, POW, ACC, DONE.
- IDLE: in_ready=1. When in_valid&&in_ready, latch num, set tmp=num, k=0 and ovf=0, then go to COUNT.
- COUNT: each cycle, tmp<=tmp/10 and k<=k+1. Leave for LOAD when the next tmp is 0. Because at least one COUNT cycle always runs, in_num=0 gives k=1.
- LOAD, 1 cycle: tmp<=num, sum<=0.
- DIGIT, 1 cycle: d<=tmp%10, tmp<=tmp/10, pw<=1, e<=0.
- POW, exactly k cycles: pw<=pw*d, e<=e+1. Exit to ACC when e==k-1.
- ACC, 1 cycle: sum<=sum+pw. If tmp==0, go to DONE; otherwise go to DIGIT.
- DONE: out_valid=1 and is_armstrong=(!ovf && sum==num). On out_ready, go to IDLE.
- Width rules:
  - pw and sum are W+1 bits.
  - Any product or sum that would reach 2^W or more saturates to 2^W and sets sticky ovf.
  - ovf forces is_armstrong=0.
- /10 and %10 are by a constant and combinational on tmp. No general divider.
- in_valid outside IDLE is ignored; the sender must hold its data.
- out_num, out_digits and is_armstrong are stable for as long as out_valid=1.

## Timing
- Reset (rst=1 at an edge), from any state, including mid-computation:
  - State returns to IDLE and the in-flight number is discarded.
  - in_ready=1 and out_valid=0 from the next cycle.
  - is_armstrong=0, out_num=0, out_digits=0.
- Latency: the accept edge is cycle 0. out_valid rises k+1+k*(k+2) cycles later.
  - k=1: 5 cycles.
  - k=3: 19 cycles.
  - k=5: 41 cycles.
- Throughput: in_ready rises the cycle after the out_valid&&out_ready edge. There is no overlap between numbers.
- Back-to-back: if in_valid is held high, the next number is accepted on the first IDLE cycle. Minimum gap between accepts = latency + 2.
- out_ready may stay high indefinitely; the DONE state lasts at least one cycle.

## Structure
- armstrong_pkg holds:
  - the state enum;
  - the function dec_digits(W), which computes MAXD;
  - the constant RADIX=10.
- Sub-module digit_pow: sequential saturating power unit.
  - Inputs: start, d[3:0], k.
  - Outputs: pw[W:0], sat, done.
  - Takes exactly k cycles after start.
  - It owns the POW state's datapath. The top FSM sequences it.

## Test plan
- W=9, in_num=153 → out_valid 19 cycles after accept; is_armstrong=1, out_digits=3, out_num=153.
- W=9, in_num=154, then in_num=0 back-to-back with in_valid held high:
  - 154 → is_armstrong=0 after 19 cycles.
  - 0 → is_armstrong=1, out_digits=1, after 5 cycles.
- W=16, in_num=9474 → is_armstrong=1, out_digits=4, after 29 cycles. in_num=59999 → ovf set, is_armstrong=0, after 41 cycles.
- W=9, sweep every number from 0 to 511 with random out_ready stalls:
  - is_armstrong=1 only for 0–9, 153, 370, 371 and 407.
  - Outputs stay stable during stalls.
- W=9, in_num=370, rst pulsed in cycle 8 → out_valid never rises. in_ready=1 the next cycle. A following 371 returns is_armstrong=1 after 19 cycles.
- W=9, in_valid toggled with new values during busy → those values are ignored, and only the accepted 407 is reported (is_armstrong=1).
